// File: rtl/deser_8way_pkg.sv
// Shared widths and FSM encoding for the 1-bit to 8-bit deserializer.
package deser_8way_pkg;
  localparam int WORD_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;
endpackage

// File: rtl/deser_8way_and8.sv
// 8-input AND gate cell.
module and8_gate (
  input  logic [7:0] a_i,
  output logic       y_o
);
  assign y_o = &a_i;
endmodule

// File: rtl/deser_8way_bit_counter_3.sv
// Mod-8 counter with synchronous clear, enable and terminal-count flag.
module bit_counter_3
  import deser_8way_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CNT_W'(WORD_W - 1));
endmodule

// File: rtl/deser_8way.sv
// Collects eight accepted serial bits into a byte and holds it on a
// valid/ready output together with a registered all-ones flag.
module deser_8way
  import deser_8way_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_all_ones
);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WORD_W - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              all_ones_q, all_ones_d;
  logic              word_and;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  pos;
  logic              tc;
  logic              accept;
  logic              word_done;

  assign accept    = in_valid && in_ready;
  assign word_done = accept && tc;

  bit_counter_3 u_cnt (
    .clk     (clk),
    .clr     (reset),
    .en      (accept),
    .count_o (cnt),
    .tc_o    (tc)
  );

  assign pos = MSB_FIRST ? (LAST_POS - cnt) : cnt;

  // shift_d is the next-word bus: current partial word plus the bit being accepted
  always_comb begin
    shift_d = shift_q;
    if (accept) shift_d[pos] = in_bit;
  end

  and8_gate u_and (
    .a_i (shift_d),
    .y_o (word_and)
  );

  always_comb begin
    out_data_d = out_data_q;
    all_ones_d = all_ones_q;
    if (word_done) begin
      out_data_d = shift_d;
      all_ones_d = word_and;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_COLLECT;
      shift_q    <= '0;
      out_data_q <= '0;
      all_ones_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
      all_ones_q <= all_ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (word_done) state_d = ST_HOLD;
      ST_HOLD:    if (out_ready) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_COLLECT);
    out_valid = (state_q == ST_HOLD);
  end

  assign out_data     = out_data_q;
  assign out_all_ones = all_ones_q;
endmodule

// File: tb/tb_deser_8way.sv
// Bench for deser_8way: LSB-first and MSB-first instances share stimulus,
// a reference model feeds per-instance expected-word queues.
module tb_deser_8way;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic       in_ready0, in_ready1;
  logic       out_valid0, out_valid1;
  logic [7:0] out_data0, out_data1;
  logic       all_ones0, all_ones1;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  deser_8way #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
    .out_ready(out_ready), .out_all_ones(all_ones0)
  );

  deser_8way #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_ready(out_ready), .out_all_ones(all_ones1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model, evaluated at the falling edge on the inputs that the next rising edge will see.
  logic [7:0] m_word0, m_word1;
  int         m_cnt  = 0;
  bit         m_hold = 1'b0;
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_in_ready0", 32'(in_ready0), 32'(!m_hold));
      chk("mon_in_ready1", 32'(in_ready1), 32'(!m_hold));
      chk("mon_out_valid0", 32'(out_valid0), 32'(m_hold));
      chk("mon_out_valid1", 32'(out_valid1), 32'(m_hold));
      if (m_hold && exp_q0.size() > 0 && exp_q1.size() > 0) begin
        chk("mon_word0", 32'({all_ones0, out_data0}), 32'(exp_q0[0]));
        chk("mon_word1", 32'({all_ones1, out_data1}), 32'(exp_q1[0]));
      end
    end
    if (reset) begin
      m_hold = 1'b0;
      m_cnt  = 0;
      m_word0 = '0;
      m_word1 = '0;
      exp_q0.delete();
      exp_q1.delete();
    end else if (!m_hold) begin
      if (in_valid) begin
        m_word0[m_cnt]     = in_bit;
        m_word1[7 - m_cnt] = in_bit;
        m_cnt++;
        if (m_cnt == 8) begin
          exp_q0.push_back({&m_word0, m_word0});
          exp_q1.push_back({&m_word1, m_word1});
          m_cnt  = 0;
          m_hold = 1'b1;
        end
      end
    end else if (out_ready) begin
      if (exp_q0.size() > 0) void'(exp_q0.pop_front());
      if (exp_q1.size() > 0) void'(exp_q1.pop_front());
      m_hold = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready0 && n < 40) begin
      step();
      n++;
    end
    if (!in_ready0) chk({tag, "_ready_timeout"}, 32'(in_ready0), 32'd1);
  endtask

  // seq[i] is the i-th bit sent; a gap of gap_len idle cycles follows bit indices ga and gb.
  task automatic send_word(input logic [7:0] seq, input int ga, input int gb, input int gap_len);
    for (int i = 0; i < 8; i++) begin
      wait_ready("send");
      in_valid = 1'b1;
      in_bit   = seq[i];
      step();
      if (i == ga || i == gb) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          in_bit = 1'($urandom_range(0, 1));
          step();
        end
      end
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [7:0] e0, input logic [7:0] e1);
    chk({tag, "_valid"}, 32'(out_valid0), 32'd1);
    chk({tag, "_data0"}, 32'(out_data0), 32'(e0));
    chk({tag, "_data1"}, 32'(out_data1), 32'(e1));
    chk({tag, "_ones0"}, 32'(all_ones0), 32'(&e0));
    chk({tag, "_ones1"}, 32'(all_ones1), 32'(&e1));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_data", 32'(out_data0), 32'h00);
    chk("rst_ones", 32'(all_ones0), 32'd0);
    mon_en = 1'b1;

    // Back-to-back word with consumer always ready
    out_ready = 1'b1;
    send_word(8'hA5, -1, -1, 0);
    chk_word("a5", 8'hA5, 8'hA5);
    chk("a5_ready_low", 32'(in_ready0), 32'd0);
    step();
    chk("a5_ready_back", 32'(in_ready0), 32'd1);
    chk("a5_valid_drop", 32'(out_valid0), 32'd0);

    // All ones with idle gaps after bits 2 and 5 (indices 1 and 4)
    send_word(8'hFF, 1, 4, 3);
    chk_word("ff", 8'hFF, 8'hFF);
    step();

    // Single leading one shows bit order
    send_word(8'h01, -1, -1, 0);
    chk_word("order", 8'h01, 8'h80);
    step();

    // Backpressure: word held while producer keeps offering bits
    out_ready = 1'b0;
    send_word(8'h3C, -1, -1, 0);
    chk_word("bp_first", 8'h3C, 8'h3C);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_bit = 1'($urandom_range(0, 1));
      step();
      chk_word("bp_hold", 8'h3C, 8'h3C);
      chk("bp_in_ready", 32'(in_ready0), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release", 32'(out_valid0), 32'd0);
    send_word(8'h01, -1, -1, 0);
    chk_word("bp_next", 8'h01, 8'h80);
    step();

    // Reset after five accepted bits
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    send_word(8'h0F, -1, -1, 0);
    chk_word("mid_rst", 8'h0F, 8'hF0);
    step();

    // Reset while holding a word
    out_ready = 1'b0;
    send_word(8'h5A, -1, -1, 0);
    chk_word("hold_pre", 8'h5A, 8'h5A);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("hold_rst_valid", 32'(out_valid0), 32'd0);
    chk("hold_rst_ready", 32'(in_ready0), 32'd1);
    repeat (3) step();

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/deser_8way.md
# deser_8way

Serial-to-parallel collector for single-bit streams. It accepts one bit per handshake on a 1-bit valid/ready input and assembles eight accepted bits into an 8-bit word. It presents that word on a valid/ready output together with an all-ones flag (the 8-input AND of the word). It sits at the receive end of any 1-bit link that must be widened back to byte width before reduction or ALU logic.

## Interface
- MSB_FIRST, 0, bit order: 0 = first accepted bit lands in out_data[0]; 1 = first accepted bit lands in out_data[7]
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- in_valid  input  1  producer has a bit on in_bit
- in_bit  input  1  serial data bit
- in_ready  output  1  block can accept a bit this cycle
- out_valid  output  1  out_data/out_all_ones hold a complete word
- out_data  output  8  assembled word
- out_all_ones  output  1  AND of all eight out_data bits
- out_ready  input  1  consumer accepts the word this cycle

## Operation
- Two states:
  - COLLECT: encoding 0, reset state.
  - HOLD: encoding 1.
- 3-bit count holds the number of bits accepted in the current word (0..7). Reset value is 0.
- in_ready = (state == COLLECT). The output is a combinational decode of the state register only and never depends on in_valid.
- Accept = in_valid && in_ready. On accept:
  - MSB_FIRST=0: the shift register loads in_bit at position count.
  - MSB_FIRST=1: the shift register loads in_bit at position 7-count.
  - count increments.
- Accept with count == 7 (8th bit):
  - the complete word (including this bit) is copied to out_data;
  - out_all_ones is registered from the same word;
  - count wraps to 0;
  - state goes to HOLD.
- HOLD:
  - out_valid = 1 and in_ready = 0.
  - in_valid is ignored and nothing is captured.
  - out_data and out_all_ones are stable.
- In HOLD, out_valid && out_ready: state goes to COLLECT next edge. out_data and out_all_ones keep their values, but are meaningful only while out_valid = 1.
- in_bit is don't-care when in_valid = 0. No bit is captured without accept.
- out_ready is ignored in COLLECT.
- Reset values:
  - in_ready = 1 (COLLECT)
  - out_valid = 0
  - out_data = 8'h00
  - out_all_ones = 0
  - count = 0
  - shift register = 0
- Reset mid-word discards the partial word.
- Reset in HOLD drops the pending word without a handshake.
- Reset dominates accept and out handshake in the same cycle.

## Timing
- Latency: 8th bit accepted at edge N gives out_valid = 1 and out_data valid in cycle N+1 (directly after edge N).
- The earliest next input accept is in the cycle after the output handshake. If out_ready = 1 continuously, the next bit is accepted at edge N+2.
- Peak throughput is 8 bits per 9 cycles.
- out_valid, out_data and out_all_ones are registered outputs. in_ready is a decode of the state register. No combinational path from any input to any output.
- out_valid, once asserted, stays high with stable data until the handshake or reset.
- Gaps (in_valid = 0) between bits are permitted at any count and do not change state.

## Structure
- Shared package / header:
  - WORD_W = 8
  - CNT_W = 3
  - state encodings ST_COLLECT = 1'b0, ST_HOLD = 1'b1
- Sub-module: bit_counter_3, a mod-8 counter with synchronous clear, enable, and a terminal-count output (count == 7). The FSM uses the terminal-count output as the word-complete condition.
- out_all_ones is computed by the library 8-input AND gate component on the next-word bus, then registered.

## Test plan
- Reset behaviour: reset held 2 cycles, then released. Required: in_ready = 1, out_valid = 0, out_data = 8'h00, out_all_ones = 0.
- Back-to-back word, MSB_FIRST=0: bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles with out_ready = 1. Required:
  - out_data = 8'hA5 and out_all_ones = 0, one cycle after the 8th accept;
  - in_ready = 0 for exactly that cycle.
- All-ones word with gaps: eight 1-bits with in_valid deasserted for 3 cycles after bits 2 and 5. Required:
  - out_data = 8'hFF and out_all_ones = 1;
  - no capture during gaps;
  - same result with MSB_FIRST=1.
- Output backpressure: complete word 8'h3C, then hold out_ready = 0 for 5 cycles while in_valid = 1 with random bits. Required:
  - out_valid and out_data = 8'h3C stable;
  - in_ready = 0 throughout;
  - after out_ready = 1, the next word collects from bit 0 cleanly.
- MSB_FIRST=1 order: bits 1,0,0,0,0,0,0,0. Required: out_data = 8'h80. Same stimulus with MSB_FIRST=0 gives 8'h01.
- Reset mid-operation:
  - reset after 5 accepted bits, then 8 new bits forming 8'h0F. Required: out_data = 8'h0F with no residue from the partial word.
  - reset in HOLD. Required: out_valid drops the next cycle.
